// File: rtl/p18240_pkg.sv
// ---------------------------------------------------------------------------
// p18240_pkg
//  Types and constants shared by the p18240 memory-port arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> ACK -> IDLE)
//   OWNER_CPU / OWNER_DBG : encoding of the owner/last-grant bit
// ---------------------------------------------------------------------------
package p18240_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_ACK    = 2'd2
   } arb_state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DBG = 1'b1;

endpackage : p18240_pkg

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//  Bundles the CPU request port, the debug/loader request port, the shared
//  memory bus and the arbiter status signals.
//   slave  : arbiter side (takes requests, drives acks/rdata/memory bus)
//   master : environment side (issues requests, models the memory)
//  Signals: cpu_req/we/addr/wdata, cpu_ack/rdata; dbg_req/we/addr/wdata,
//  dbg_ack/rdata; mem_addr/wdata/re_L/we_L, mem_rdata; busy, owner.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_ack;
   logic [DW-1:0] dbg_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_re_L;
   logic          mem_we_L;
   logic [DW-1:0] mem_rdata;

   logic          busy;
   logic          owner;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata,
      output mem_addr, mem_wdata, mem_re_L, mem_we_L,
      input  mem_rdata,
      output busy, owner
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata,
      input  mem_addr, mem_wdata, mem_re_L, mem_we_L,
      output mem_rdata,
      input  busy, owner
   );

endinterface : mem_port_arbiter_if

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
//  Two-way request picker. Purely combinational.
//   req[1:0]  : bit 0 = CPU, bit 1 = debug
//   last      : requester granted most recently (OWNER_CPU / OWNER_DBG)
//   rrEn      : 1 = alternate on a tie, 0 = CPU always wins a tie
//   grant[1:0]: one-hot winner, all zero when nobody requests
// ---------------------------------------------------------------------------
module arb_rr2
   import p18240_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       rrEn,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         // Tie: the requester that did not go last wins when alternating.
         if (rrEn && (last == OWNER_CPU)) begin
            grant = 2'b10;
         end else begin
            grant = 2'b01;
         end
      end
   end

endmodule : arb_rr2

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//  Shares the single p18240 memory port between the CPU and the debug/loader
//  port. One access at a time: the winner's we/addr/wdata are latched, one
//  memory enable is held low for MEM_LAT cycles, read data is captured in the
//  last access cycle and the owner receives a one-cycle ack.
//  Ports:
//   clock : system clock, all state changes on posedge
//   reset : synchronous active-high reset
//   bus   : mem_port_arbiter_if.slave (requests, acks, memory bus, status)
//  Parameters: AW/DW (must match bus), MEM_LAT (>=1), RR_EN.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import p18240_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2,
   parameter bit RR_EN   = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   arb_state_t    stateReg, stateNext;
   logic [CW-1:0] cntReg, cntNext;
   logic          weReg, weNext;
   logic [AW-1:0] addrReg, addrNext;
   logic [DW-1:0] wdataReg, wdataNext;
   logic          ownerReg, ownerNext;
   logic          lastReg, lastNext;
   logic [DW-1:0] rdataReg  [2];
   logic [DW-1:0] rdataNext [2];

   logic [1:0]    grant;
   logic [1:0]    ackVec;

   arb_rr2 uPicker (
      .req   ({bus.dbg_req, bus.cpu_req}),
      .last  (lastReg),
      .rrEn  (RR_EN),
      .grant (grant)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         stateReg    <= ARB_IDLE;
         cntReg      <= '0;
         weReg       <= 1'b0;
         addrReg     <= '0;
         wdataReg    <= '0;
         ownerReg    <= OWNER_CPU;
         lastReg     <= OWNER_DBG;   // CPU wins the first tie
         rdataReg[0] <= '0;
         rdataReg[1] <= '0;
      end else begin
         stateReg    <= stateNext;
         cntReg      <= cntNext;
         weReg       <= weNext;
         addrReg     <= addrNext;
         wdataReg    <= wdataNext;
         ownerReg    <= ownerNext;
         lastReg     <= lastNext;
         rdataReg[0] <= rdataNext[0];
         rdataReg[1] <= rdataNext[1];
      end
   end

   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      weNext    = weReg;
      addrNext  = addrReg;
      wdataNext = wdataReg;
      ownerNext = ownerReg;
      lastNext  = lastReg;
      rdataNext = rdataReg;

      case (stateReg)
         ARB_IDLE: begin
            if (grant[0]) begin
               ownerNext = OWNER_CPU;
               weNext    = bus.cpu_we;
               addrNext  = bus.cpu_addr;
               wdataNext = bus.cpu_wdata;
               cntNext   = CW'(MEM_LAT - 1);
               stateNext = ARB_ACCESS;
            end else if (grant[1]) begin
               ownerNext = OWNER_DBG;
               weNext    = bus.dbg_we;
               addrNext  = bus.dbg_addr;
               wdataNext = bus.dbg_wdata;
               cntNext   = CW'(MEM_LAT - 1);
               stateNext = ARB_ACCESS;
            end
         end

         ARB_ACCESS: begin
            // Requests are ignored here: a latched access always runs to its ack.
            if (cntReg == '0) begin
               if (!weReg) begin
                  rdataNext[ownerReg] = bus.mem_rdata;
               end
               stateNext = ARB_ACK;
            end else begin
               cntNext = cntReg - CW'(1);
            end
         end

         ARB_ACK: begin
            lastNext  = ownerReg;
            stateNext = ARB_IDLE;
         end

         default: stateNext = ARB_IDLE;
      endcase
   end

   // Ack is decoded from registered state, so it is a clean one-cycle pulse
   // and only the owner's bit can be set.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : genAck
         assign ackVec[gi] = (stateReg == ARB_ACK) && (ownerReg == 1'(gi));
      end
   endgenerate

   assign bus.cpu_ack   = ackVec[0];
   assign bus.dbg_ack   = ackVec[1];
   assign bus.cpu_rdata = rdataReg[0];
   assign bus.dbg_rdata = rdataReg[1];

   assign bus.mem_addr  = addrReg;
   assign bus.mem_wdata = wdataReg;
   assign bus.mem_re_L  = !((stateReg == ARB_ACCESS) && !weReg);
   assign bus.mem_we_L  = !((stateReg == ARB_ACCESS) &&  weReg);

   assign bus.busy      = (stateReg != ARB_IDLE);
   assign bus.owner     = ownerReg;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//  Directed bench for mem_port_arbiter. dut1 runs round-robin, dut0 runs
//  fixed priority (only exercised by the both-requesting sequence).
//  Inputs change 1 time unit after posedge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clock;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;

   mem_port_arbiter_if #(.AW(16), .DW(16)) bus1 ();
   mem_port_arbiter_if #(.AW(16), .DW(16)) bus0 ();

   mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .RR_EN(1'b1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1.slave)
   );

   mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .RR_EN(1'b0)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
      bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = 0; bus1.dbg_wdata = 0;
      bus1.mem_rdata = 0;
      bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
      bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;
      bus0.mem_rdata = 0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_busy",  bus1.busy,      0);
      check("rst_reL",   bus1.mem_re_L,  1);
      check("rst_weL",   bus1.mem_we_L,  1);
      check("rst_cack",  bus1.cpu_ack,   0);
      check("rst_dack",  bus1.dbg_ack,   0);
      check("rst_owner", bus1.owner,     0);
      check("rst_addr",  bus1.mem_addr,  0);
      check("rst_wdata", bus1.mem_wdata, 0);
      check("rst_crd",   bus1.cpu_rdata, 0);
      check("rst_drd",   bus1.dbg_rdata, 0);
      $display("txn reset: idle state checked");

      // 1: CPU read 0x0100, memory returns 0xBEEF
      bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h0100;
      bus1.mem_rdata = 16'hBEEF;
      tick();
      check("t1_c1_busy", bus1.busy,     1);
      check("t1_c1_reL",  bus1.mem_re_L, 0);
      check("t1_c1_weL",  bus1.mem_we_L, 1);
      check("t1_c1_addr", bus1.mem_addr, 16'h0100);
      check("t1_c1_own",  bus1.owner,    0);
      check("t1_c1_ack",  bus1.cpu_ack,  0);
      tick();
      check("t1_c2_reL",  bus1.mem_re_L, 0);
      check("t1_c2_ack",  bus1.cpu_ack,  0);
      tick();
      check("t1_c3_cack", bus1.cpu_ack,   1);
      check("t1_c3_dack", bus1.dbg_ack,   0);
      check("t1_c3_rd",   bus1.cpu_rdata, 16'hBEEF);
      check("t1_c3_reL",  bus1.mem_re_L,  1);
      bus1.cpu_req = 0;
      bus1.mem_rdata = 16'h1234;
      tick();
      check("t1_c4_cack", bus1.cpu_ack,   0);
      check("t1_c4_busy", bus1.busy,      0);
      check("t1_c4_hold", bus1.cpu_rdata, 16'hBEEF);
      $display("txn 1: cpu read 0100 -> %h", bus1.cpu_rdata);

      // 2: debug write 0x2000 <- 0x00FF
      bus1.dbg_req = 1; bus1.dbg_we = 1; bus1.dbg_addr = 16'h2000; bus1.dbg_wdata = 16'h00FF;
      tick();
      check("t2_c1_weL",   bus1.mem_we_L,  0);
      check("t2_c1_reL",   bus1.mem_re_L,  1);
      check("t2_c1_addr",  bus1.mem_addr,  16'h2000);
      check("t2_c1_wdata", bus1.mem_wdata, 16'h00FF);
      check("t2_c1_own",   bus1.owner,     1);
      tick();
      check("t2_c2_weL",   bus1.mem_we_L,  0);
      check("t2_c2_dack",  bus1.dbg_ack,   0);
      tick();
      check("t2_c3_dack",  bus1.dbg_ack,   1);
      check("t2_c3_cack",  bus1.cpu_ack,   0);
      check("t2_c3_weL",   bus1.mem_we_L,  1);
      bus1.dbg_req = 0;
      tick();
      check("t2_c4_dack",  bus1.dbg_ack,   0);
      check("t2_c4_busy",  bus1.busy,      0);
      check("t2_c4_crd",   bus1.cpu_rdata, 16'hBEEF);
      check("t2_c4_drd",   bus1.dbg_rdata, 0);
      $display("txn 2: dbg write 2000 <- 00FF");

      // 3 + 4: both requesting from reset; dut1 alternates, dut0 always CPU
      reset = 1'b1;
      bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h0010;
      bus1.dbg_req = 1; bus1.dbg_we = 0; bus1.dbg_addr = 16'h0020;
      bus1.mem_rdata = 16'h7777;
      bus0.cpu_req = 1; bus0.dbg_req = 1;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check($sformatf("t3_k%0d_cack", k), bus1.cpu_ack, ((k == 3) || (k == 11)) ? 1 : 0);
         check($sformatf("t3_k%0d_dack", k), bus1.dbg_ack, ((k == 7) || (k == 15)) ? 1 : 0);
         check($sformatf("t4_k%0d_cack", k), bus0.cpu_ack, ((k % 4) == 3) ? 1 : 0);
         check($sformatf("t4_k%0d_dack", k), bus0.dbg_ack, 0);
         if (bus1.cpu_ack || bus1.dbg_ack)
            $display("txn 3: cycle %0d ack cpu=%0d dbg=%0d", k, bus1.cpu_ack, bus1.dbg_ack);
         if (k == 15) begin
            bus1.cpu_req = 0; bus1.dbg_req = 0;
            bus0.cpu_req = 0; bus0.dbg_req = 0;
         end
      end
      check("t3_drd", bus1.dbg_rdata, 16'h7777);
      check("t3_crd", bus1.cpu_rdata, 16'h7777);

      // 5: cpu_req dropped in first ACCESS cycle
      bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h0300;
      bus1.mem_rdata = 16'h5A5A;
      tick();
      check("t5_c1_busy", bus1.busy, 1);
      bus1.cpu_req = 0;
      tick();
      tick();
      check("t5_c3_cack", bus1.cpu_ack,   1);
      check("t5_c3_rd",   bus1.cpu_rdata, 16'h5A5A);
      for (int k = 4; k <= 8; k++) begin
         tick();
         check($sformatf("t5_k%0d_busy", k), bus1.busy,    0);
         check($sformatf("t5_k%0d_cack", k), bus1.cpu_ack, 0);
      end
      $display("txn 5: dropped cpu read 0300 -> %h", bus1.cpu_rdata);

      // 6: reset in the middle of a CPU write, then a fresh debug read
      bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 16'h0400; bus1.cpu_wdata = 16'h1111;
      tick();
      check("t6_c1_weL", bus1.mem_we_L, 0);
      reset = 1'b1;
      tick();
      check("t6_r_busy", bus1.busy,      0);
      check("t6_r_reL",  bus1.mem_re_L,  1);
      check("t6_r_weL",  bus1.mem_we_L,  1);
      check("t6_r_cack", bus1.cpu_ack,   0);
      check("t6_r_dack", bus1.dbg_ack,   0);
      check("t6_r_addr", bus1.mem_addr,  0);
      check("t6_r_crd",  bus1.cpu_rdata, 0);
      reset = 1'b0;
      bus1.cpu_req = 0;
      bus1.dbg_req = 1; bus1.dbg_we = 0; bus1.dbg_addr = 16'h0500;
      bus1.mem_rdata = 16'hCAFE;
      tick();
      check("t6_c1_reL",  bus1.mem_re_L, 0);
      check("t6_c1_own",  bus1.owner,    1);
      check("t6_c1_addr", bus1.mem_addr, 16'h0500);
      tick();
      tick();
      check("t6_c3_dack", bus1.dbg_ack,   1);
      check("t6_c3_cack", bus1.cpu_ack,   0);
      check("t6_c3_rd",   bus1.dbg_rdata, 16'hCAFE);
      bus1.dbg_req = 0;
      tick();
      check("t6_c4_dack", bus1.dbg_ack, 0);
      check("t6_c4_busy", bus1.busy,    0);
      $display("txn 6: dbg read 0500 after reset -> %h", bus1.dbg_rdata);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_mem_port_arbiter
